// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: reset/bring-up sequencer for the FPGA SoC top.
// Holds the MIG in reset, waits for MMCM lock and MIG calibration, then
// releases the SoC reset after a settle delay and latches the boot mode.
// Loss of lock or calibration, or a reset request, restarts the sequence.
// Optional feature macro: RST_SEQ_CALIB_TIMEOUT_EN enables the calibration
// timeout, the ERROR state and the sticky calib_err_o flag. Without it the
// sequencer waits for calibration indefinitely and calib_err_o is 0.
// state_o exposes the FSM encoding for debug and VIO probing.
// req_rst_i is a level request, not a handshake: while it is high the FSM
// sits in RESET with the counter cleared.
module fpga_rst_seq #(
   parameter int unsigned DramRstCycles = 16,
   parameter int unsigned SocRelDelay   = 64,
   parameter int unsigned CalibTimeout  = 2**24 - 1,
   parameter int unsigned SyncStages    = 2,
   parameter int unsigned CntWidth      = 24
) (
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       req_rst_i,
   input  logic       mmcm_locked_i,
   input  logic       calib_done_i,
   input  logic [1:0] boot_mode_i,
   output logic       dram_sys_rst_o,
   output logic       soc_rst_no,
   output logic [1:0] boot_mode_o,
   output logic [2:0] state_o,
   output logic       calib_err_o
);

   typedef enum logic [2:0] {
      ST_RESET      = 3'd0,
      ST_WAIT_LOCK  = 3'd1,
      ST_WAIT_CALIB = 3'd2,
      ST_DELAY      = 3'd3,
      ST_RUN        = 3'd4,
      ST_ERROR      = 3'd5
   } state_t;

`ifdef RST_SEQ_CALIB_TIMEOUT_EN
   localparam logic TimeoutEn = 1'b1;
`else
   localparam logic TimeoutEn = 1'b0;
`endif

   // Terminal counts: each phase lasts exactly N cycles, so compare to N-1.
   localparam logic [CntWidth-1:0] DramLast  = CntWidth'(DramRstCycles - 1);
   localparam logic [CntWidth-1:0] SocLast   = CntWidth'(SocRelDelay - 1);
   localparam logic [CntWidth-1:0] CalibLast = CntWidth'(CalibTimeout - 1);

   logic [SyncStages-1:0] r_lock_sync;
   logic [SyncStages-1:0] r_calib_sync;
   state_t                r_state;
   logic [CntWidth-1:0]   r_cnt;
   logic                  r_dram_rst;
   logic                  r_soc_rst_n;
   logic [1:0]            r_boot_mode;
   logic                  r_calib_err;

   logic                  w_lock_sync;
   logic                  w_calib_sync;
   logic [CntWidth-1:0]   w_cnt_inc;
   logic                  w_timeout_hit;

   assign w_lock_sync   = r_lock_sync[SyncStages-1];
   assign w_calib_sync  = r_calib_sync[SyncStages-1];
   // Saturating increment: the counter must never wrap back to a terminal count.
   assign w_cnt_inc     = (r_cnt == {CntWidth{1'b1}}) ? r_cnt : r_cnt + 1'b1;
   // Constant 0 when the timeout feature is compiled out.
   assign w_timeout_hit = TimeoutEn & (r_cnt == CalibLast);

   // Multi-flop synchronisers for the asynchronous lock and calibration inputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_lock_sync  <= '0;
         r_calib_sync <= '0;
      end else begin
         r_lock_sync  <= {r_lock_sync[SyncStages-2:0], mmcm_locked_i};
         r_calib_sync <= {r_calib_sync[SyncStages-2:0], calib_done_i};
      end
   end

   // Sequencer FSM with shared counter and registered outputs.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state     <= ST_RESET;
         r_cnt       <= '0;
         r_dram_rst  <= 1'b1;
         r_soc_rst_n <= 1'b0;
         r_boot_mode <= 2'b00;
         r_calib_err <= 1'b0;
      end else if (req_rst_i) begin
         // A request wins over every other transition, including a timeout.
         r_state     <= ST_RESET;
         r_cnt       <= '0;
         r_dram_rst  <= 1'b1;
         r_soc_rst_n <= 1'b0;
         r_calib_err <= 1'b0;
      end else begin
         case (r_state)
            ST_RESET: begin
               if (r_cnt == DramLast) begin
                  r_state    <= ST_WAIT_LOCK;
                  r_cnt      <= '0;
                  r_dram_rst <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            ST_WAIT_LOCK: begin
               if (w_lock_sync) begin
                  r_state <= ST_WAIT_CALIB;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            ST_WAIT_CALIB: begin
               if (!w_lock_sync) begin
                  r_state     <= ST_RESET;
                  r_cnt       <= '0;
                  r_dram_rst  <= 1'b1;
                  r_soc_rst_n <= 1'b0;
                  r_calib_err <= 1'b0;
               end else if (w_calib_sync) begin
                  r_state <= ST_DELAY;
                  r_cnt   <= '0;
               end else if (w_timeout_hit) begin
                  r_state     <= ST_ERROR;
                  r_cnt       <= '0;
                  r_dram_rst  <= 1'b0;
                  r_soc_rst_n <= 1'b0;
                  r_calib_err <= 1'b1;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            ST_DELAY: begin
               if (!w_lock_sync || !w_calib_sync) begin
                  r_state     <= ST_RESET;
                  r_cnt       <= '0;
                  r_dram_rst  <= 1'b1;
                  r_soc_rst_n <= 1'b0;
                  r_calib_err <= 1'b0;
               end else if (r_cnt == SocLast) begin
                  // The only edge on which the boot mode is captured.
                  r_state     <= ST_RUN;
                  r_cnt       <= '0;
                  r_soc_rst_n <= 1'b1;
                  r_boot_mode <= boot_mode_i;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            ST_RUN: begin
               if (!w_lock_sync || !w_calib_sync) begin
                  r_state     <= ST_RESET;
                  r_cnt       <= '0;
                  r_dram_rst  <= 1'b1;
                  r_soc_rst_n <= 1'b0;
                  r_calib_err <= 1'b0;
               end else begin
                  r_cnt <= w_cnt_inc;
               end
            end

            ST_ERROR: begin
               // Parked until a reset request; outputs hold their entry values.
               r_cnt <= w_cnt_inc;
            end

            default: begin
               r_state     <= ST_RESET;
               r_cnt       <= '0;
               r_dram_rst  <= 1'b1;
               r_soc_rst_n <= 1'b0;
               r_calib_err <= 1'b0;
            end
         endcase
      end
   end

   assign dram_sys_rst_o = r_dram_rst;
   assign soc_rst_no     = r_soc_rst_n;
   assign boot_mode_o    = r_boot_mode;
   assign state_o        = r_state;
   assign calib_err_o    = r_calib_err & TimeoutEn;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb_fpga_rst_seq: directed bench for fpga_rst_seq with
// DramRstCycles=4, SocRelDelay=8, SyncStages=2, CalibTimeout=100.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// Timeout expectations follow RST_SEQ_CALIB_TIMEOUT_EN.
module tb_fpga_rst_seq;

   localparam int unsigned DramRstCycles = 4;
   localparam int unsigned SocRelDelay   = 8;
   localparam int unsigned CalibTimeout  = 100;
   localparam int unsigned SyncStages    = 2;
   localparam int unsigned CntWidth      = 24;

`ifdef RST_SEQ_CALIB_TIMEOUT_EN
   localparam logic [2:0] ExpTimeoutState = 3'd5;
   localparam logic       ExpTimeoutErr   = 1'b1;
`else
   localparam logic [2:0] ExpTimeoutState = 3'd2;
   localparam logic       ExpTimeoutErr   = 1'b0;
`endif

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic       req_rst_i;
   logic       mmcm_locked_i;
   logic       calib_done_i;
   logic [1:0] boot_mode_i;
   logic       dram_sys_rst_o;
   logic       soc_rst_no;
   logic [1:0] boot_mode_o;
   logic [2:0] state_o;
   logic       calib_err_o;

   int checks   = 0;
   int failures = 0;

   // Clock generation.
   always #5 clk_i = ~clk_i;

   fpga_rst_seq #(
      .DramRstCycles (DramRstCycles),
      .SocRelDelay   (SocRelDelay),
      .CalibTimeout  (CalibTimeout),
      .SyncStages    (SyncStages),
      .CntWidth      (CntWidth)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .req_rst_i      (req_rst_i),
      .mmcm_locked_i  (mmcm_locked_i),
      .calib_done_i   (calib_done_i),
      .boot_mode_i    (boot_mode_i),
      .dram_sys_rst_o (dram_sys_rst_o),
      .soc_rst_no     (soc_rst_no),
      .boot_mode_o    (boot_mode_o),
      .state_o        (state_o),
      .calib_err_o    (calib_err_o)
   );

   // Advance n rising edges, ending 1 time unit after the last one.
   task automatic step(input int n);
      repeat (n) @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_dram"},  {31'd0, dram_sys_rst_o}, 32'd1);
      check({tag, "_soc"},   {31'd0, soc_rst_no},     32'd0);
      check({tag, "_boot"},  {30'd0, boot_mode_o},    32'd0);
      check({tag, "_state"}, {29'd0, state_o},        32'd0);
      check({tag, "_err"},   {31'd0, calib_err_o},    32'd0);
   endtask

   initial begin
      rst_ni        = 1'b0;
      req_rst_i     = 1'b0;
      mmcm_locked_i = 1'b1;
      calib_done_i  = 1'b1;
      boot_mode_i   = 2'b10;
      step(3);
      check_reset_values("rst");

      // T1: nominal bring-up, release counted from here.
      rst_ni = 1'b1;
      step(3);
      check("t1_dram_hold", {31'd0, dram_sys_rst_o}, 32'd1);
      check("t1_state_reset", {29'd0, state_o}, 32'd0);
      step(1);
      check("t1_dram_fall", {31'd0, dram_sys_rst_o}, 32'd0);
      check("t1_state_wlock", {29'd0, state_o}, 32'd1);
      step(9);
      check("t1_soc_hold", {31'd0, soc_rst_no}, 32'd0);
      check("t1_state_delay", {29'd0, state_o}, 32'd3);
      step(1);
      check("t1_soc_rise", {31'd0, soc_rst_no}, 32'd1);
      check("t1_state_run", {29'd0, state_o}, 32'd4);
      check("t1_boot", {30'd0, boot_mode_o}, 32'd2);

      // T5b: boot mode change in RUN is not captured.
      boot_mode_i = 2'b01;
      step(5);
      check("t5_boot_hold", {30'd0, boot_mode_o}, 32'd2);

      // T4: lock loss in RUN, then recovery re-latches boot mode.
      mmcm_locked_i = 1'b0;
      step(2);
      check("t4_soc_still", {31'd0, soc_rst_no}, 32'd1);
      step(1);
      check("t4_soc_fall", {31'd0, soc_rst_no}, 32'd0);
      check("t4_state_reset", {29'd0, state_o}, 32'd0);
      check("t4_dram_rise", {31'd0, dram_sys_rst_o}, 32'd1);
      step(3);
      check("t4_dram_hold", {31'd0, dram_sys_rst_o}, 32'd1);
      step(1);
      check("t4_dram_fall", {31'd0, dram_sys_rst_o}, 32'd0);
      check("t4_state_wlock", {29'd0, state_o}, 32'd1);
      step(5);
      check("t4_wait_lock", {29'd0, state_o}, 32'd1);
      mmcm_locked_i = 1'b1;
      step(3);
      check("t4_state_wcal", {29'd0, state_o}, 32'd2);
      step(1);
      check("t4_state_delay", {29'd0, state_o}, 32'd3);
      step(7);
      check("t4_soc_hold", {31'd0, soc_rst_no}, 32'd0);
      step(1);
      check("t4_state_run", {29'd0, state_o}, 32'd4);
      check("t4_boot_new", {30'd0, boot_mode_o}, 32'd1);

      // T2: late calibration. Held request keeps counter cleared.
      calib_done_i = 1'b0;
      req_rst_i    = 1'b1;
      step(1);
      check("t2_req_state", {29'd0, state_o}, 32'd0);
      check("t2_req_soc", {31'd0, soc_rst_no}, 32'd0);
      step(2);
      check("t2_req_hold", {29'd0, state_o}, 32'd0);
      req_rst_i = 1'b0;
      step(4);
      check("t2_state_wlock", {29'd0, state_o}, 32'd1);
      step(1);
      check("t2_state_wcal", {29'd0, state_o}, 32'd2);
      step(50);
      calib_done_i = 1'b1;
      // First edge samples the rise; DELAY follows two cycles after that.
      step(2);
      check("t2_still_wcal", {29'd0, state_o}, 32'd2);
      step(1);
      check("t2_state_delay", {29'd0, state_o}, 32'd3);
      check("t2_err_low", {31'd0, calib_err_o}, 32'd0);
      step(7);
      check("t2_soc_hold", {31'd0, soc_rst_no}, 32'd0);
      step(1);
      check("t2_soc_rise", {31'd0, soc_rst_no}, 32'd1);
      check("t2_err_run", {31'd0, calib_err_o}, 32'd0);

      // T3: calibration timeout, then recovery by request.
      calib_done_i = 1'b0;
      req_rst_i    = 1'b1;
      step(1);
      check("t3_req_state", {29'd0, state_o}, 32'd0);
      req_rst_i = 1'b0;
      step(4);
      check("t3_state_wlock", {29'd0, state_o}, 32'd1);
      step(1);
      check("t3_state_wcal", {29'd0, state_o}, 32'd2);
      step(99);
      check("t3_pre_timeout", {29'd0, state_o}, 32'd2);
      check("t3_pre_err", {31'd0, calib_err_o}, 32'd0);
      step(1);
      check("t3_timeout_state", {29'd0, state_o}, {29'd0, ExpTimeoutState});
      check("t3_timeout_err", {31'd0, calib_err_o}, {31'd0, ExpTimeoutErr});
      check("t3_err_dram", {31'd0, dram_sys_rst_o}, 32'd0);
      check("t3_err_soc", {31'd0, soc_rst_no}, 32'd0);
      step(10);
      check("t3_err_sticky", {29'd0, state_o}, {29'd0, ExpTimeoutState});
      req_rst_i = 1'b1;
      step(1);
      check("t3_clr_state", {29'd0, state_o}, 32'd0);
      check("t3_clr_err", {31'd0, calib_err_o}, 32'd0);
      check("t3_clr_dram", {31'd0, dram_sys_rst_o}, 32'd1);
      req_rst_i = 1'b0;
      step(4);
      check("t3_restart_wlock", {29'd0, state_o}, 32'd1);
      step(1);
      check("t3_restart_wcal", {29'd0, state_o}, 32'd2);

      // T5a: request on the timeout cycle wins.
      step(99);
      check("t5_pre_timeout", {29'd0, state_o}, 32'd2);
      req_rst_i = 1'b1;
      step(1);
      check("t5_tie_state", {29'd0, state_o}, 32'd0);
      check("t5_tie_err", {31'd0, calib_err_o}, 32'd0);
      check("t5_tie_dram", {31'd0, dram_sys_rst_o}, 32'd1);

      // T6: asynchronous reset during DELAY.
      req_rst_i    = 1'b0;
      calib_done_i = 1'b1;
      step(4);
      check("t6_state_wlock", {29'd0, state_o}, 32'd1);
      step(1);
      check("t6_state_wcal", {29'd0, state_o}, 32'd2);
      step(1);
      check("t6_state_delay", {29'd0, state_o}, 32'd3);
      step(3);
      #2;
      rst_ni = 1'b0;
      #1;
      check_reset_values("t6_async");
      step(2);
      boot_mode_i = 2'b11;
      rst_ni      = 1'b1;
      step(3);
      check("t6_dram_hold", {31'd0, dram_sys_rst_o}, 32'd1);
      step(1);
      check("t6_dram_fall", {31'd0, dram_sys_rst_o}, 32'd0);
      check("t6_state_wlock2", {29'd0, state_o}, 32'd1);
      step(9);
      check("t6_soc_hold", {31'd0, soc_rst_no}, 32'd0);
      step(1);
      check("t6_soc_rise", {31'd0, soc_rst_no}, 32'd1);
      check("t6_boot", {30'd0, boot_mode_o}, 32'd3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
